// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core
//   Stopwatch core: NDIG-digit BCD time counter, start/stop/recall FSM and a
//   DEPTH-entry lap buffer that can be stepped through in recall mode.
//   Ports:
//     clk          system clock
//     rst          asynchronous reset, active-low
//     tick         count strobe, counts only in RUN
//     start_stop   pulse: toggle run/stop, leaves recall
//     lap          pulse: capture running time into lap buffer
//     clear        pulse: zero counter, laps and overflow (not in RUN)
//     recall       pulse: enter recall / step to next lap
//     digits       displayed BCD value (digit 0 in [3:0]), registered
//     running      high while displaying RUN
//     recall_mode  high while displaying RECALL
//     lap_idx      lap currently selected in RECALL (0 = oldest)
//     lap_count    number of stored laps
//     lap_full     lap buffer full
//     overflow     sticky: counter wrapped past all-9s
//
// state  | meaning
// IDLE   | cleared, counter at zero, no laps
// RUN    | counting ticks, lap captures allowed
// STOP   | counter held, may resume, clear or recall
// RECALL | displaying stored lap lap_idx
module stopwatch_lap_core #(
  parameter int NDIG  = 8,
  parameter int DEPTH = 4,
  localparam int LAPW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  input  logic              recall,
  output logic [4*NDIG-1:0] digits,
  output logic              running,
  output logic              recall_mode,
  output logic [LAPW-2:0]   lap_idx,
  output logic [LAPW-1:0]   lap_count,
  output logic              lap_full,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RUN, STOP, RECALL} state_t;

  localparam logic [LAPW-1:0] FULL_CNT = LAPW'(DEPTH);

  state_t state_q, state_d;

  logic [4*NDIG-1:0] cnt;
  logic [4*NDIG-1:0] cnt_inc;
  logic              wrap;
  logic [4*NDIG-1:0] lap_mem [DEPTH];

  logic do_clear, do_lap, rec_enter, rec_step, count_en;
  logic has_laps, full_int, last_idx;

  assign has_laps = (lap_count != '0);
  assign full_int = (lap_count == FULL_CNT);
  assign last_idx = ({1'b0, lap_idx} == (lap_count - 1'b1));
  // Counting looks at the current state, so a tick coincident with the
  // stopping pulse is still counted.
  assign count_en = (state_q == RUN) && tick;

  // BCD ripple increment; wrap is the carry out of the top digit.
  always_comb begin
    logic carry;
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_clear  = 1'b0;
    do_lap    = 1'b0;
    rec_enter = 1'b0;
    rec_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          do_clear = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end else if (recall && has_laps) begin
          state_d   = RECALL;
          rec_enter = 1'b1;
        end
      end
      RUN: begin
        // lap is independent of start_stop here: a lap on the stopping
        // cycle still captures the pre-stop value.
        if (start_stop) state_d = STOP;
        if (lap && !full_int) do_lap = 1'b1;
      end
      STOP: begin
        if (clear) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (start_stop) begin
          state_d = RUN;
        end else if (recall && has_laps) begin
          state_d   = RECALL;
          rec_enter = 1'b1;
        end
      end
      RECALL: begin
        if (clear) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (start_stop) begin
          state_d = STOP;
        end else if (recall) begin
          rec_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lap_count <= '0;
      lap_idx   <= '0;
      overflow  <= 1'b0;
    end else if (do_clear) begin
      cnt       <= '0;
      lap_count <= '0;
      lap_idx   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (count_en) begin
        cnt <= cnt_inc;
        if (wrap) overflow <= 1'b1;
      end
      if (do_lap) lap_count <= lap_count + 1'b1;
      if (rec_enter) lap_idx <= '0;
      else if (rec_step) lap_idx <= last_idx ? '0 : lap_idx + 1'b1;
    end
  end

  // Captures the registered counter, i.e. the value before this cycle's tick.
  always_ff @(posedge clk) begin
    if (do_lap) lap_mem[lap_count[LAPW-2:0]] <= cnt;
  end

  // Display stage: all flags come from the same state sample as digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits      <= '0;
      running     <= 1'b0;
      recall_mode <= 1'b0;
      lap_full    <= 1'b0;
    end else begin
      digits      <= (state_q == RECALL) ? lap_mem[lap_idx] : cnt;
      running     <= (state_q == RUN);
      recall_mode <= (state_q == RECALL);
      lap_full    <= full_int;
    end
  end

endmodule
